// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
//   Reader end of the FFT output interface. Takes one complete N-point frame
//   from the FFT's parallel real/imag arrays and streams it out one complex
//   bin per beat over a valid/ready handshake. With BIT_REVERSE=1 the
//   bit-reversed bin order of the FFT is undone, so bins leave in natural
//   order 0..N-1.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   frame_valid  parallel frame on frame_real/frame_imag is valid
//   frame_ready  serializer can accept a frame this cycle
//   frame_real   signed real bins, one per array element
//   frame_imag   signed imag bins, one per array element
//   out_valid    out_real/out_imag/out_index/out_last carry a beat
//   out_ready    downstream accepts the current beat
//   out_real     signed real part of the current bin
//   out_imag     signed imag part of the current bin
//   out_index    natural-order bin index of the current beat
//   out_last     current beat is bin N-1 (end of frame)
//   drop_count   saturating count of cycles a frame was offered but refused

module fft_frame_serializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int N           = 16,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic signed [DATA_WIDTH-1:0] frame_real [N-1:0],
  input  logic signed [DATA_WIDTH-1:0] frame_imag [N-1:0],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic [$clog2(N)-1:0]         out_index,
  output logic                         out_last,
  output logic [7:0]                   drop_count
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                        state;
  state_t                        state_next;
  logic [IW-1:0]                 k;
  logic [IW-1:0]                 k_next;
  logic signed [DATA_WIDTH-1:0]  buf_real [N-1:0];
  logic signed [DATA_WIDTH-1:0]  buf_imag [N-1:0];
  logic [IW-1:0]                 rev_tbl  [N-1:0];
  logic [IW-1:0]                 rd_sel;
  logic                          last_beat;
  logic                          accept;
  logic                          xfer;
  logic                          drop_hit;

  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int b = 0; b < IW; b++) begin
      r[b] = v[IW-1-b];
    end
    return r;
  endfunction

  // Bit-reversal is a fixed permutation, so it becomes a constant lookup
  // table; the only runtime logic is the read mux indexed by k.
  for (genvar i = 0; i < N; i++) begin : g_rev
    localparam logic [IW-1:0] REV = bitrev(IW'(i));
    assign rev_tbl[i] = REV;
  end

  assign rd_sel    = BIT_REVERSE ? rev_tbl[k] : k;
  assign last_beat = (k == IW'(N - 1));

  assign out_real  = buf_real[rd_sel];
  assign out_imag  = buf_imag[rd_sel];
  assign out_index = k;
  assign out_last  = (state == STREAM) && last_beat;

  // frame_ready opens on the final beat's transfer so a waiting frame can
  // be captured on the same edge, giving zero-bubble back-to-back frames.
  always_comb begin
    state_next  = state;
    k_next      = k;
    frame_ready = 1'b0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        frame_ready = !rst;
      end
      STREAM: begin
        out_valid   = 1'b1;
        frame_ready = !rst && last_beat && out_ready;
      end
      default: begin
        frame_ready = 1'b0;
      end
    endcase

    accept   = frame_valid && frame_ready;
    xfer     = out_valid && out_ready;
    drop_hit = frame_valid && !frame_ready && !rst;

    // k wraps naturally from N-1 to 0, so IDLE always sits at index 0.
    if (xfer) begin
      k_next = k + IW'(1);
    end
    if (accept) begin
      k_next = '0;
    end

    case (state)
      IDLE: begin
        if (accept) state_next = STREAM;
      end
      STREAM: begin
        if (xfer && last_beat) state_next = accept ? STREAM : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      drop_count <= '0;
      for (int i = 0; i < N; i++) begin
        buf_real[i] <= '0;
        buf_imag[i] <= '0;
      end
    end else begin
      state <= state_next;
      k     <= k_next;
      if (accept) begin
        for (int i = 0; i < N; i++) begin
          buf_real[i] <= frame_real[i];
          buf_imag[i] <= frame_imag[i];
        end
      end
      if (drop_hit && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb_fft_frame_serializer
//   Self-checking bench for fft_frame_serializer. Two instances share every
//   input: one bit-reversing, one natural-order. Expected values come from a
//   hand-written table of bit-reversed bin numbers.

module tb_fft_frame_serializer;

  localparam int DW = 16;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst;
  logic frame_valid;
  logic out_ready;
  logic signed [DW-1:0] frame_real [N-1:0];
  logic signed [DW-1:0] frame_imag [N-1:0];

  logic                 fr_r, ov_r, last_r;
  logic signed [DW-1:0] re_r, im_r;
  logic [3:0]           idx_r;
  logic [7:0]           dc_r;

  logic                 fr_n, ov_n, last_n;
  logic signed [DW-1:0] re_n, im_n;
  logic [3:0]           idx_n;
  logic [7:0]           dc_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int bin;
    int last;
  } vec_t;

  vec_t vecs [N];
  int   rev_bins [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int   bp_pat   [4] = '{1, 0, 0, 1};

  fft_frame_serializer #(.DATA_WIDTH(DW), .N(N), .BIT_REVERSE(1'b1)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(fr_r),
    .frame_real(frame_real), .frame_imag(frame_imag),
    .out_valid(ov_r), .out_ready(out_ready), .out_real(re_r), .out_imag(im_r),
    .out_index(idx_r), .out_last(last_r), .drop_count(dc_r)
  );

  fft_frame_serializer #(.DATA_WIDTH(DW), .N(N), .BIT_REVERSE(1'b0)) dut_nat (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(fr_n),
    .frame_real(frame_real), .frame_imag(frame_imag),
    .out_valid(ov_n), .out_ready(out_ready), .out_real(re_n), .out_imag(im_n),
    .out_index(idx_n), .out_last(last_n), .drop_count(dc_n)
  );

  always #5 clk = ~clk;

  // Hard stop in case the handshake locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock, then drive new inputs away from the edge and let
  // combinational outputs settle before anything is sampled.
  task automatic applyStimulus(input logic r, input logic fv, input logic ordy);
    @(posedge clk);
    #1;
    rst         = r;
    frame_valid = fv;
    out_ready   = ordy;
    #1;
  endtask

  task automatic loadFrame(input int base, input int step);
    for (int i = 0; i < N; i++) begin
      frame_real[i] = DW'(base + i * step);
      frame_imag[i] = DW'(-i);
    end
  endtask

  task automatic acceptFrame(input int base, input int step,
                             input logic fv_after, input logic ordy_after);
    loadFrame(base, step);
    frame_valid = 1'b1;
    #1;
    checkOutput("accept frame_ready", int'(fr_r), 1);
    applyStimulus(1'b0, fv_after, ordy_after);
  endtask

  task automatic checkBeat(input string tag, input int k, input int base, input int step);
    checkOutput($sformatf("%s k%0d out_valid", tag, k), int'(ov_r), 1);
    checkOutput($sformatf("%s k%0d out_index", tag, k), int'(idx_r), vecs[k].idx);
    checkOutput($sformatf("%s k%0d rev real", tag, k), int'(re_r), base + vecs[k].bin * step);
    checkOutput($sformatf("%s k%0d rev imag", tag, k), int'(im_r), -vecs[k].bin);
    checkOutput($sformatf("%s k%0d out_last", tag, k), int'(last_r), vecs[k].last);
    checkOutput($sformatf("%s k%0d nat valid", tag, k), int'(ov_n), 1);
    checkOutput($sformatf("%s k%0d nat real", tag, k), int'(re_n), base + k * step);
    checkOutput($sformatf("%s k%0d nat imag", tag, k), int'(im_n), -k);
  endtask

  initial begin
    int xk;
    int cyc;

    for (int k = 0; k < N; k++) begin
      vecs[k] = '{idx: k, bin: rev_bins[k], last: (k == N - 1) ? 1 : 0};
    end

    rst         = 1'b1;
    frame_valid = 1'b1;
    out_ready   = 1'b1;
    loadFrame(0, 100);

    // T1: reset held with a frame offered.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("T1 frame_ready", int'(fr_r), 0);
      checkOutput("T1 out_valid", int'(ov_r), 0);
      checkOutput("T1 drop_count", int'(dc_r), 0);
    end
    checkOutput("T1 out_real", int'(re_r), 0);
    checkOutput("T1 out_index", int'(idx_r), 0);
    checkOutput("T1 out_last", int'(last_r), 0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle frame_ready", int'(fr_r), 1);
    checkOutput("idle out_valid", int'(ov_r), 0);

    // T2/T3: one frame, both orderings, first beat one cycle after accept.
    acceptFrame(0, 100, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) begin
      checkBeat("T23", k, 0, 100);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("T23 end out_valid", int'(ov_r), 0);
    checkOutput("T23 end nat valid", int'(ov_n), 0);
    checkOutput("T23 end frame_ready", int'(fr_r), 1);

    // T4: backpressure with out_ready pattern 1,0,0,1.
    acceptFrame(0, 7, 1'b0, 1'b1);
    xk  = 0;
    cyc = 0;
    while (xk < N && cyc < 100) begin
      checkBeat("T4", xk, 0, 7);
      if (out_ready) xk++;
      cyc++;
      applyStimulus(1'b0, 1'b0, bp_pat[cyc % 4] != 0);
    end
    checkOutput("T4 transfers", xk, N);
    checkOutput("T4 cycles", cyc, 32);
    checkOutput("T4 end out_valid", int'(ov_r), 0);

    // T5: second frame offered during beat 15 follows with no bubble.
    acceptFrame(0, 1, 1'b0, 1'b1);
    for (int k = 0; k < N - 1; k++) begin
      checkBeat("T5a", k, 0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkBeat("T5a", N - 1, 0, 1);
    loadFrame(1000, 1);
    frame_valid = 1'b1;
    #1;
    checkOutput("T5 last-beat frame_ready", int'(fr_r), 1);
    checkOutput("T5 last-beat nat ready", int'(fr_n), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) begin
      checkBeat("T5b", k, 1000, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("T5 end out_valid", int'(ov_r), 0);
    checkOutput("T5 drop_count", int'(dc_r), 0);

    // T6: refusals during beats 0..14 count 15.
    acceptFrame(0, 3, 1'b1, 1'b1);
    for (int k = 0; k < N - 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkBeat("T6", N - 1, 0, 3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("T6 drop 15", int'(dc_r), 15);
    checkOutput("T6 drop 15 nat", int'(dc_n), 15);
    checkOutput("T6 idle out_valid", int'(ov_r), 0);

    // Stalled stream with a frame offered every cycle: count then saturate.
    acceptFrame(0, 5, 1'b1, 1'b0);
    for (int c = 0; c < 200; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("T6 drop 215", int'(dc_r), 215);
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("T6 drop sat", int'(dc_r), 255);
    checkOutput("T6 drop sat nat", int'(dc_n), 255);
    checkBeat("T6 stall", 0, 0, 5);

    // Reset mid-frame discards the rest of the frame.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkBeat("T6 resume", 2, 0, 5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("T6 rst frame_ready", int'(fr_r), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("T6 rst out_valid", int'(ov_r), 0);
    checkOutput("T6 rst drop_count", int'(dc_r), 0);
    checkOutput("T6 rst out_index", int'(idx_r), 0);
    checkOutput("T6 rst out_real", int'(re_r), 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("T6 post-rst out_valid", int'(ov_r), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
